mem_image_loader: RTL

Session-based loader that streams a program/data image into the core's instruction and data memories over a valid/ready word stream. It drives the datapath's external-load ports (`enable_load_ex_mem`, `InstExMem*`, `DataExMem*`) directly. While a session runs, the core pipeline, PC and register file are held in their initialization state. When the last beat has been committed, the core is released.

---
 rtl/mem_image_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_image_loader.sv
// rtl/mem_image_loader.sv - streams a framed program/data image into the core memories via the external-load ports
// Optional trailing checksum word is compiled in with MEM_LOADER_CHECKSUM_EN.
module mem_image_loader #(
  parameter int PC_W       = 9,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  enable_load_ex_mem,
  output logic [PC_W-1:0]       InstExMemAddress,
  output logic [DATA_W-1:0]     InstExMemData1,
  output logic [DATA_W-1:0]     InstExMemData2,
  output logic [DM_ADDRESS-1:0] DataExMemAddress,
  output logic [DATA_W-1:0]     DataExMemData1,
  output logic [DATA_W-1:0]     DataExMemData2,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    COLLECT = 3'd2,
`ifdef MEM_LOADER_CHECKSUM_EN
    CSUM    = 3'd3,
`endif
    DRAIN   = 3'd4
  } state_t;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_t POST_PAYLOAD = CSUM;
`else
  localparam state_t POST_PAYLOAD = DRAIN;
`endif

  state_t            state, next_state;
  logic              accept;
  logic [15:0]       hdr_base;
  logic [15:0]       cur_addr;
  logic [15:0]       remaining;
  logic [1:0]        word_idx;
  logic              drain_cnt;
  logic [DATA_W-1:0] stage0, stage1, stage2;

  assign accept   = s_valid && s_ready;
  assign busy     = (state != IDLE);
  // Beats are 8-byte aligned, so the low three base bits are discarded.
  assign hdr_base = s_data[31:16] & 16'hFFF8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = HDR;
      end
      HDR: begin
        s_ready = 1'b1;
        if (s_valid) next_state = (s_data[15:0] == 16'd0) ? POST_PAYLOAD : COLLECT;
      end
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && word_idx == 2'd3 && remaining == 16'd1) next_state = POST_PAYLOAD;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      CSUM: begin
        s_ready = 1'b1;
        if (s_valid) next_state = DRAIN;
      end
`endif
      DRAIN: begin
        if (drain_cnt) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_load_ex_mem <= 1'b0;
      InstExMemAddress   <= '0;
      InstExMemData1     <= '0;
      InstExMemData2     <= '0;
      DataExMemAddress   <= '0;
      DataExMemData1     <= '0;
      DataExMemData2     <= '0;
      done               <= 1'b0;
      cur_addr           <= '0;
      remaining          <= '0;
      word_idx           <= '0;
      drain_cnt          <= 1'b0;
      stage0             <= '0;
      stage1             <= '0;
      stage2             <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            enable_load_ex_mem <= 1'b1;
            InstExMemAddress   <= '0;
            InstExMemData1     <= '0;
            InstExMemData2     <= '0;
            DataExMemAddress   <= '0;
            DataExMemData1     <= '0;
            DataExMemData2     <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            cur_addr         <= hdr_base;
            remaining        <= s_data[15:0];
            word_idx         <= 2'd0;
            InstExMemAddress <= hdr_base[PC_W-1:0];
            DataExMemAddress <= hdr_base[DM_ADDRESS-1:0];
          end
        end
        COLLECT: begin
          if (accept) begin
            word_idx <= word_idx + 2'd1;
            case (word_idx)
              2'd0: stage0 <= s_data;
              2'd1: stage1 <= s_data;
              2'd2: stage2 <= s_data;
              default: begin
                // Whole beat commits on one edge so the memories never see a torn pair.
                InstExMemAddress <= cur_addr[PC_W-1:0];
                DataExMemAddress <= cur_addr[DM_ADDRESS-1:0];
                InstExMemData1   <= stage0;
                InstExMemData2   <= stage1;
                DataExMemData1   <= stage2;
                DataExMemData2   <= s_data;
                cur_addr         <= cur_addr + 16'd8;
                remaining        <= remaining - 16'd1;
              end
            endcase
          end
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) begin
            enable_load_ex_mem <= 1'b0;
            done               <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        csum <= '0;
        err  <= 1'b0;
      end else if (state == COLLECT && accept) begin
        csum <= csum + s_data[31:0];
      end else if (state == CSUM && accept && s_data[31:0] != csum) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
